uart_tx_tick: RTL and testbench
===============================

# uart_tx_tick

Tick-driven UART transmitter: accepts one byte per valid/ready handshake and serialises it LSB-first as start bit, DATA_BITS data bits, optional parity bit and STOP_BITS stop bits on `txd`. Bit timing comes entirely from the single-cycle `tick` strobe produced by an upstream `clock_gen` instance configured for the baud rate (e.g. `clk_fre = 115200`). The block sits between the core's MMIO/UART register logic and the board TX pin.

## Interface
- DATA_BITS, 8, data bits per frame (5..8)
- STOP_BITS, 1, stop bits per frame (1 or 2)
- PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored unless UART_TX_PARITY_EN is defined
- clk  input  1  system clock, 100 MHz
- reset  input  1  asynchronous, active-low reset (asserted at 0)
- tick  input  1  one-clk-wide baud strobe from clock_gen
- tx_data  input  DATA_BITS  byte to send, sampled at handshake
- tx_valid  input  1  producer has data
- tx_ready  output  1  block can accept; high only in IDLE
- txd  output  1  serial line, idle high, registered
- busy  output  1  high in every state except IDLE

## Operation
- Handshake: transfer when `tx_valid && tx_ready` at a rising `clk`; `tx_data` latched into shift register, parity precomputed; `tx_data` may change afterwards.
- FSM states: IDLE, SYNC, START, DATA, PARITY, STOP. All transitions except IDLE->SYNC occur only on cycles with `tick = 1`.
- IDLE: `txd = 1`; on handshake -> SYNC. A `tick` in the handshake cycle is ignored.
- SYNC: on tick, `txd <= 0` -> START.
- START: on tick, `txd <= shift[0]`, shift right, bit_cnt <= 0 -> DATA.
- DATA: on tick, if bit_cnt == DATA_BITS-1: -> PARITY with `txd <= parity` (macro defined) else -> STOP with `txd <= 1`, stop_cnt <= 0; otherwise `txd <=` next bit, bit_cnt++.
- PARITY: on tick, `txd <= 1`, stop_cnt <= 0 -> STOP.
- STOP: on tick, if stop_cnt == STOP_BITS-1 -> IDLE, else stop_cnt++.
- Parity: even = XOR of data bits; odd = XNOR.
- bit_cnt width $clog2(DATA_BITS), stop_cnt 1 bit; no wrap beyond terminal counts.
- `tx_valid` while not IDLE: held off (tx_ready = 0), nothing lost or duplicated.

## Timing
- Reset (reset = 0, async): state IDLE, `txd = 1`, `tx_ready = 1`, `busy = 0`, counters and shift register 0.
- Reset mid-frame: `txd` returns to 1 immediately, frame abandoned, no partial resume after release.
- Start bit edge: first tick strictly after handshake cycle; latency 1..P clk, P = tick period.
- Every bit lasts exactly one tick interval (P clk); `txd` changes only in the clk after a tick.
- Frame = 1 + DATA_BITS + (1 if parity) + STOP_BITS bit periods from start edge to IDLE.
- `tx_ready` rises the cycle after the final stop tick; back-to-back frames carry one extra idle-high bit period (SYNC wait) between last stop bit and next start bit.
- `tick` stuck high: block advances one bit per clk; legal, used in test.

## Configuration
- UART_TX_PARITY_EN defined: PARITY state present, parity bit inserted after data per PARITY_ODD.
- Not defined: PARITY state, parity register and PARITY_ODD logic compiled out; DATA goes directly to STOP.

## Structure
- Shared package `uart_pkg`: state enum typedef (`uart_tx_state_t`), default DATA_BITS/STOP_BITS constants, reused by the future receiver.
- Single module; no sub-module. `clock_gen` instantiated at top level, not inside.

## Test plan
- Reset: hold reset = 0 with tx_valid = 1 -> txd = 1, tx_ready = 1, busy = 0; no frame starts until release.
- tick every 4 clk, send 0x55, no parity, STOP_BITS=1 -> txd per bit: 0,1,0,1,0,1,0,1,0,1; each 4 clk; tx_ready back high 1 clk after 10th bit.
- UART_TX_PARITY_EN, PARITY_ODD=0, send 0x07 -> parity bit 1; PARITY_ODD=1 -> parity bit 0; 0xA3 even -> 0.
- STOP_BITS=2, two back-to-back bytes 0xA3, 0x0F with tx_valid held -> stop high for 2 bits plus 1 idle bit, second start; tx_ready low throughout each frame.
- Handshake coincident with tick -> start bit begins at the next tick, not the current one.
- Assert reset during data bit 3 of 0xFF -> txd = 1 asynchronously; after release, new 0x01 transmits cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and default frame format.
// Reused by the transmitter and the future receiver.
`timescale 1ns/1ps
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_tick.sv
// Tick-driven UART transmitter: start, LSB-first data, optional parity, stop bits.
// Parity bit is present only when UART_TX_PARITY_EN is defined.
`timescale 1ns/1ps
module uart_tx_tick
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int STOP_BITS  = UART_STOP_BITS,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 busy
);

  localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_tx_tick: unsupported parameter set");
  end

  uart_tx_state_t       state_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic [CNT_W-1:0]     bit_cnt_reg;
  logic                 stop_cnt_reg;
  logic                 txd_reg;
`ifdef UART_TX_PARITY_EN
  logic                 parity_reg;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      txd_reg      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        // A tick coinciding with the handshake is deliberately not used here.
        ST_IDLE: begin
          if (tx_valid) begin
            shift_reg <= tx_data;
`ifdef UART_TX_PARITY_EN
            parity_reg <= (^tx_data) ^ PARITY_ODD[0];
`endif
            state_reg <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (tick) begin
            txd_reg   <= 1'b0;
            state_reg <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            txd_reg     <= shift_reg[0];
            shift_reg   <= shift_reg >> 1;
            bit_cnt_reg <= '0;
            state_reg   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_cnt_reg == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              txd_reg   <= parity_reg;
              state_reg <= ST_PARITY;
`else
              txd_reg      <= 1'b1;
              stop_cnt_reg <= 1'b0;
              state_reg    <= ST_STOP;
`endif
            end else begin
              txd_reg     <= shift_reg[0];
              shift_reg   <= shift_reg >> 1;
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            txd_reg      <= 1'b1;
            stop_cnt_reg <= 1'b0;
            state_reg    <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            if (stop_cnt_reg == LAST_STOP) state_reg <= ST_IDLE;
            else stop_cnt_reg <= 1'b1;
          end
        end
        default: begin
          txd_reg   <= 1'b1;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign txd      = txd_reg;
  assign tx_ready = (state_reg == ST_IDLE);
  assign busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_tick.sv
// Self-checking bench for uart_tx_tick: two instances (1 stop/even, 2 stop/odd)
// compared against a frame-level reference model, plus vector table and corner sequences.
`timescale 1ns/1ps
module tb_uart_tx_tick;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic [7:0] tx_data [2];
  logic       tx_valid [2];
  logic       tx_ready [2];
  logic       txd [2];
  logic       busy [2];

  int checks = 0;
  int failures = 0;

  localparam int ODDS [2] = '{0, 1};
  localparam int STOPS [2] = '{1, 2};
`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  always #5 clk = ~clk;

  uart_tx_tick #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
    .clk(clk), .reset(reset), .tick(tick), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .txd(txd[0]), .busy(busy[0]));

  uart_tx_tick #(.DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(1)) dut_b (
    .clk(clk), .reset(reset), .tick(tick), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .txd(txd[1]), .busy(busy[1]));

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Tick source: 0 periodic, 1 stuck high, 2 random, 3 driven by hand.
  int tick_mode = 0;
  int tick_period = 4;
  int tick_cnt = 0;
  always @(negedge clk) begin
    case (tick_mode)
      0: begin
        tick_cnt = (tick_cnt + 1) % tick_period;
        tick = (tick_cnt == 0);
      end
      1: tick = 1'b1;
      2: tick = ($urandom_range(0, 2) == 0);
      default: ;
    endcase
  end

  // Reference model: a frame is a list of line levels, one consumed per tick;
  // the tick after the list runs dry returns the line to idle.
  function automatic logic [15:0] frame_of(input logic [7:0] d, input int odd);
    logic [15:0] v;
    int n;
    v = '1;
    v[0] = 1'b0;
    n = 1;
    for (int i = 0; i < 8; i++) begin
      v[n] = d[i];
      n++;
    end
    if (PAR_BITS == 1) v[n] = (^d) ^ (odd != 0);
    return v;
  endfunction

  logic        m_busy [2];
  logic        m_txd [2];
  logic [15:0] m_bits [2];
  int          m_left [2];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        m_busy[k] <= 1'b0;
        m_txd[k]  <= 1'b1;
        m_left[k] <= 0;
        m_bits[k] <= '1;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!m_busy[k]) begin
          if (tx_valid[k]) begin
            m_busy[k] <= 1'b1;
            m_bits[k] <= frame_of(tx_data[k], ODDS[k]);
            m_left[k] <= 1 + 8 + PAR_BITS + STOPS[k];
          end
        end else if (tick) begin
          if (m_left[k] != 0) begin
            m_txd[k]  <= m_bits[k][0];
            m_bits[k] <= m_bits[k] >> 1;
            m_left[k] <= m_left[k] - 1;
          end else begin
            m_busy[k] <= 1'b0;
          end
        end
      end
    end
  end

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk1(k == 0 ? "model_txd_a" : "model_txd_b", txd[k], m_txd[k]);
        chk1(k == 0 ? "model_ready_a" : "model_ready_b", tx_ready[k], !m_busy[k]);
        chk1(k == 0 ? "model_busy_a" : "model_busy_b", busy[k], m_busy[k]);
      end
    end
  end

  task automatic wait_start(input int k);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (txd[k] === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk1("start_seen", ok, 1'b1);
  endtask

  task automatic wait_idle(input int k);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (tx_ready[k] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk1("idle_seen", ok, 1'b1);
  endtask

  // Send one byte on dut_a and sample each bit at its first cycle.
  task automatic send_check(input logic [7:0] d, input int p, input logic par);
    logic [15:0] exp;
    int len;
    exp = '1;
    exp[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp[i+1] = d[i];
    if (PAR_BITS == 1) exp[9] = par;
    len = 10 + PAR_BITS;
    wait_idle(0);
    tx_data[0] = d;
    tx_valid[0] = 1'b1;
    @(negedge clk);
    tx_valid[0] = 1'b0;
    tx_data[0] = ~d;
    wait_start(0);
    for (int i = 0; i < len; i++) begin
      if (i > 0) repeat (p) @(negedge clk);
      chk1($sformatf("bit%0d_of_%h", i, d), txd[0], exp[i]);
    end
    if (p > 1) begin
      repeat (p - 1) @(negedge clk);
      chk1("ready_low_in_last_stop", tx_ready[0], 1'b0);
    end
    @(negedge clk);
    chk1("ready_after_stop", tx_ready[0], 1'b1);
    $display("frame a data=%h period=%0d done", d, p);
  endtask

  typedef struct {
    logic [7:0] data;
    int         period;
    logic       par_even;
  } vec_t;
  vec_t vecs [6];

  initial begin
    int n1, n2, ready_hi, sent, t;
    bit hs_pend, armed;
    bit hs_r [2];

    vecs[0] = '{8'h55, 4, 1'b0};
    vecs[1] = '{8'h07, 4, 1'b1};
    vecs[2] = '{8'hA3, 3, 1'b0};
    vecs[3] = '{8'h00, 1, 1'b0};
    vecs[4] = '{8'hFF, 5, 1'b0};
    vecs[5] = '{8'h80, 2, 1'b1};

    // Reset held with a pending request: nothing may start.
    tx_data[0] = 8'h3C; tx_data[1] = 8'hC3;
    tx_valid[0] = 1'b1; tx_valid[1] = 1'b1;
    chk_en = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk1("rst_txd", txd[0], 1'b1);
      chk1("rst_ready", tx_ready[0], 1'b1);
      chk1("rst_busy", busy[1], 1'b0);
    end
    tx_valid[0] = 1'b0; tx_valid[1] = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk1("post_rst_idle", busy[0], 1'b0);

    for (int v = 0; v < 6; v++) begin
      tick_period = vecs[v].period;
      repeat (3) @(negedge clk);
      send_check(vecs[v].data, vecs[v].period, vecs[v].par_even);
    end

    // Handshake on a tick cycle: that tick must not start the frame.
    tick_mode = 3;
    @(negedge clk);
    tick = 1'b0;
    repeat (2) @(negedge clk);
    tx_data[0] = 8'h81; tx_valid[0] = 1'b1; tick = 1'b1;
    @(negedge clk);
    tx_valid[0] = 1'b0; tick = 1'b0;
    chk1("hs_tick_busy", busy[0], 1'b1);
    chk1("hs_tick_ignored", txd[0], 1'b1);
    repeat (2) @(negedge clk);
    chk1("sync_wait", txd[0], 1'b1);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    chk1("start_after_tick", txd[0], 1'b0);
    $display("coincident handshake sequence done");
    tick_period = 2;
    tick_mode = 0;
    wait_idle(0);

    // Back-to-back frames on dut_b with valid held.
    tick_period = 4;
    tx_data[1] = 8'hA3; tx_valid[1] = 1'b1;
    sent = 0; hs_pend = 0; armed = 0; n1 = 0; n2 = 0; ready_hi = 0;
    for (t = 0; t < 600 && (sent < 2 || armed); t++) begin
      @(negedge clk);
      if (hs_pend) begin
        sent++;
        armed = 1'b1;
        if (sent == 1) tx_data[1] = 8'h0F;
        else tx_valid[1] = 1'b0;
      end
      if (armed && txd[1] === 1'b0) begin
        armed = 1'b0;
        if (sent == 1) n1 = t;
        else n2 = t;
      end
      if (sent == 1 && !armed && tx_ready[1]) ready_hi++;
      hs_pend = tx_valid[1] && tx_ready[1];
    end
    chkn("b2b_frames_sent", sent, 2);
    chkn("b2b_start_spacing", n2 - n1, (1 + 8 + PAR_BITS + 2 + 1) * 4);
    chkn("b2b_ready_gap_cycles", ready_hi, 1);
    $display("back-to-back frames done spacing=%0d", n2 - n1);
    wait_idle(1);

    // Reset during data bit 3 (0xFF on a, 0x00 on b so the line is low on b).
    tx_data[0] = 8'hFF; tx_data[1] = 8'h00;
    tx_valid[0] = 1'b1; tx_valid[1] = 1'b1;
    @(negedge clk);
    tx_valid[0] = 1'b0; tx_valid[1] = 1'b0;
    wait_start(0);
    repeat (4 * 4 + 1) @(negedge clk);
    chk1("d3_level_a", txd[0], 1'b1);
    chk1("d3_level_b", txd[1], 1'b0);
    #2 reset = 1'b0;
    #1;
    chk1("async_txd_b", txd[1], 1'b1);
    chk1("async_ready_a", tx_ready[0], 1'b1);
    chk1("async_busy_a", busy[0], 1'b0);
    chk1("async_busy_b", busy[1], 1'b0);
    tx_valid[0] = 1'b1;
    repeat (4) @(negedge clk);
    tx_valid[0] = 1'b0;
    #2 reset = 1'b1;
    @(negedge clk);
    chk1("no_resume_a", busy[0], 1'b0);
    chk1("no_resume_txd_b", txd[1], 1'b1);
    $display("mid-frame reset sequence done");
    send_check(8'h01, 4, 1'b1);

    // Randomised traffic on both instances under varying tick patterns.
    hs_r[0] = 0; hs_r[1] = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (c % 400 == 0) begin
        tick_mode = $urandom_range(0, 2);
        tick_period = $urandom_range(1, 6);
        $display("random phase c=%0d tick_mode=%0d period=%0d", c, tick_mode, tick_period);
      end
      for (int k = 0; k < 2; k++) begin
        if (hs_r[k] || !tx_valid[k]) begin
          tx_valid[k] = ($urandom_range(0, 2) == 0);
          tx_data[k] = 8'($urandom);
        end
        hs_r[k] = tx_valid[k] && tx_ready[k];
      end
    end
    tx_valid[0] = 1'b0; tx_valid[1] = 1'b0;
    tick_mode = 0; tick_period = 2;
    wait_idle(0);
    wait_idle(1);
    @(negedge clk);
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
